if_stage: RTL

IF_STAGE -- requirements
Module: if_stage

---
 rtl/if_stage.sv | 139 +++++++++++++
 1 files changed

// File: rtl/if_stage.sv
// Instruction fetch stage: PC, one in-flight memory request and a 2-entry {pc, instr} buffer.
// Ports: clock/reset; imem_req/imem_addr/imem_rdata to instruction memory;
// redirect_valid/redirect_pc from execute; id_valid/id_pc/id_instr/id_ready to decode;
// fetch_misalign is a sticky flag that is active only when IF_MISALIGN_CHECK_EN is defined.
module if_stage #(
    parameter logic [31:0] RESET_PC  = 32'h0000_0000,
    parameter int          BUF_DEPTH = 2
) (
    input  logic        clock,
    input  logic        reset,
    output logic        imem_req,
    output logic [31:0] imem_addr,
    input  logic [31:0] imem_rdata,
    input  logic        redirect_valid,
    input  logic [31:0] redirect_pc,
    input  logic        id_ready,
    output logic        id_valid,
    output logic [31:0] id_pc,
    output logic [31:0] id_instr,
    output logic        fetch_misalign
);

    localparam logic [2:0] DEPTH = 3'(BUF_DEPTH);

    logic [31:0] pc_q, pc_d;
    logic [1:0]  cnt_q, cnt_d;
    logic [31:0] pc0_q, pc0_d, ins0_q, ins0_d;
    logic [31:0] pc1_q, pc1_d, ins1_q, ins1_d;
    logic        infl_q, infl_d;
    logic [31:0] infl_pc_q, infl_pc_d;
    logic        mis_q, mis_d;

    logic [31:0] tgt;
    logic        tgt_bad;
    logic        pop;
    logic        cap;
    logic        room;

`ifdef IF_MISALIGN_CHECK_EN
    assign tgt     = redirect_pc;
    assign tgt_bad = |redirect_pc[1:0];
`else
    logic unused_lo;
    assign unused_lo = ^redirect_pc[1:0];
    assign tgt       = {redirect_pc[31:2], 2'b00};
    assign tgt_bad   = 1'b0;
`endif

    assign id_valid       = (cnt_q != 2'd0);
    assign id_pc          = pc0_q;
    assign id_instr       = ins0_q;
    assign fetch_misalign = mis_q;
    assign imem_addr      = pc_q;

    assign pop  = id_valid & id_ready;
    assign cap  = infl_q;
    // A pop frees a slot this cycle, so a request may still issue when full.
    assign room = (({1'b0, cnt_q} + {2'b00, infl_q}) < DEPTH) | pop;

    assign imem_req = ~reset & ~redirect_valid & ~mis_q & room;

    always_comb begin
        pc_d      = pc_q;
        cnt_d     = cnt_q;
        pc0_d     = pc0_q;
        ins0_d    = ins0_q;
        pc1_d     = pc1_q;
        ins1_d    = ins1_q;
        infl_d    = 1'b0;
        infl_pc_d = infl_pc_q;
        mis_d     = mis_q;
        if (redirect_valid) begin
            // Flush wins over any same-cycle pop or capture.
            cnt_d = 2'd0;
            pc_d  = tgt;
            mis_d = tgt_bad;
        end else begin
            if (imem_req) begin
                pc_d      = pc_q + 32'd4;
                infl_d    = 1'b1;
                infl_pc_d = pc_q;
            end
            case ({pop, cap})
                2'b01: begin
                    if (cnt_q == 2'd0) begin
                        pc0_d  = infl_pc_q;
                        ins0_d = imem_rdata;
                    end else begin
                        pc1_d  = infl_pc_q;
                        ins1_d = imem_rdata;
                    end
                    cnt_d = cnt_q + 2'd1;
                end
                2'b10: begin
                    pc0_d  = pc1_q;
                    ins0_d = ins1_q;
                    cnt_d  = cnt_q - 2'd1;
                end
                2'b11: begin
                    if (cnt_q == 2'd1) begin
                        pc0_d  = infl_pc_q;
                        ins0_d = imem_rdata;
                    end else begin
                        pc0_d  = pc1_q;
                        ins0_d = ins1_q;
                        pc1_d  = infl_pc_q;
                        ins1_d = imem_rdata;
                    end
                end
                default: ;
            endcase
        end
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            pc_q      <= RESET_PC;
            cnt_q     <= 2'd0;
            pc0_q     <= 32'd0;
            ins0_q    <= 32'd0;
            pc1_q     <= 32'd0;
            ins1_q    <= 32'd0;
            infl_q    <= 1'b0;
            infl_pc_q <= 32'd0;
            mis_q     <= 1'b0;
        end else begin
            pc_q      <= pc_d;
            cnt_q     <= cnt_d;
            pc0_q     <= pc0_d;
            ins0_q    <= ins0_d;
            pc1_q     <= pc1_d;
            ins1_q    <= ins1_d;
            infl_q    <= infl_d;
            infl_pc_q <= infl_pc_d;
            mis_q     <= mis_d;
        end
    end

endmodule
